// File: rtl/seg_scan_monitor.sv
// seg_scan_monitor: scanned 7-segment debug display with a debounced button that steps the channel.
// Each scan shows one snapshot, so a value never tears across digits.
module seg_scan_monitor #(
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_CH      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEBOUNCE    = 500000,
    parameter int LZ_BLANK    = 1,
    localparam int DATA_W     = 4 * NUM_DIGITS,
    localparam int CW         = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic                     selButton,
    input  logic                     hold,
    output logic [7:0]               disp7Seg,
    output logic [NUM_DIGITS-1:0]    selDisp,
    output logic [CW-1:0]            ch_sel
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int DW = $clog2(DEBOUNCE);
    localparam logic [15:0][6:0] HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    logic [RW-1:0]     ref_cnt;
    logic [IW-1:0]     dig;
    logic [DATA_W-1:0] snap;
    logic [DW-1:0]     db_cnt;
    logic              s1, s2, db, ch_chg;
    logic              tick, wrap, step, z, blank;
    logic [CW-1:0]     ch_nxt;
    logic [3:0]        nib;

    always_comb begin
        tick   = ref_cnt == RW'(REFRESH_DIV - 1);
        wrap   = tick && dig == IW'(NUM_DIGITS - 1);
        step   = NUM_CH > 1 && db_cnt == DW'(DEBOUNCE - 1) && s2 && !db;
        ch_nxt = !step ? ch_sel : ch_sel == CW'(NUM_CH - 1) ? '0 : ch_sel + 1'b1;
        nib    = snap[4*dig +: 4];
        z      = 1'b1;
        blank  = 1'b0;
        // z tracks "this nibble and everything above it is zero", walking down from the top
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            z = z && snap[4*i +: 4] == 4'h0;
            if (IW'(i) == dig) blank = z && LZ_BLANK != 0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ref_cnt  <= '0;
            dig      <= '0;
            snap     <= '0;
            db_cnt   <= '0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            db       <= 1'b0;
            ch_chg   <= 1'b0;
            ch_sel   <= '0;
            selDisp  <= ~NUM_DIGITS'(1);
            disp7Seg <= 8'hC0;
        end else begin
            ref_cnt <= tick ? '0 : ref_cnt + 1'b1;
            if (tick) dig <= dig == IW'(NUM_DIGITS - 1) ? '0 : dig + 1'b1;
            s1     <= selButton;
            s2     <= s1;
            db_cnt <= s1 != s2 ? '0 : db_cnt == DW'(DEBOUNCE - 1) ? db_cnt : db_cnt + 1'b1;
            if (db_cnt == DW'(DEBOUNCE - 1)) db <= s2;
            ch_sel <= ch_nxt;
            ch_chg <= step;
            // loading from ch_nxt lets a step coinciding with the wrap show the new channel at once
            if ((wrap && !hold) || ch_chg) snap <= data_in[ch_nxt*DATA_W +: DATA_W];
            selDisp  <= ~(NUM_DIGITS'(1) << dig);
            disp7Seg <= {!(hold && dig == '0), blank ? 7'h7F : HEX[nib]};
        end
    end
endmodule

// File: tb/tb_seg_scan_monitor.sv
// tb_seg_scan_monitor: directed checks of scanning, blanking, hold and button stepping.
module tb_seg_scan_monitor;
    logic        Clk = 1'b0, Rst_n = 1'b0, selButton = 1'b0, hold = 1'b0;
    logic [63:0] data_in;
    logic [7:0]  disp7Seg;
    logic [3:0]  selDisp;
    logic [1:0]  ch_sel;
    int          n_chk = 0, n_fail = 0;

    seg_scan_monitor #(
        .NUM_DIGITS(4), .NUM_CH(4), .REFRESH_DIV(4), .DEBOUNCE(3), .LZ_BLANK(1)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .data_in(data_in), .selButton(selButton), .hold(hold),
        .disp7Seg(disp7Seg), .selDisp(selDisp), .ch_sel(ch_sel)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // returns on the first sample of digit 0 after the n-th scan wrap
    task automatic wait_wrap(input int n);
        logic [3:0] p;
        int t;
        for (int k = 0; k < n; k++) begin
            p = selDisp;
            for (t = 0; t < 100; t++) begin
                @(negedge Clk);
                if (p == 4'h7 && selDisp == 4'hE) break;
                p = selDisp;
            end
            check("wrap_seen", 32'(t < 100), 32'd1);
        end
    endtask

    task automatic scan(input string tag, input logic [3:0][7:0] e);
        logic [3:0] sel_e;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (d != 0 || c != 0) @(negedge Clk);
                sel_e = ~(4'b1 << d);
                check(tag, {selDisp, disp7Seg}, {sel_e, e[d]});
            end
        end
    endtask

    task automatic press(input int n);
        @(negedge Clk) selButton = 1'b1;
        repeat (n) @(negedge Clk);
        selButton = 1'b0;
        repeat (10) @(negedge Clk);
    endtask

    initial begin
        data_in = {16'h3333, 16'h2222, 16'h1111, 16'h12AF};
        repeat (3) @(negedge Clk);
        check("rst_sel", selDisp, 4'hE);
        check("rst_seg", disp7Seg, 8'hC0);
        check("rst_ch", ch_sel, 0);
        Rst_n = 1'b1;

        wait_wrap(1);
        scan("t1_12af", {8'hF9, 8'hA4, 8'h88, 8'h8E});
        data_in[15:0] = 16'h0050;
        wait_wrap(2);
        scan("t2_0050", {8'hFF, 8'hFF, 8'h92, 8'hC0});
        data_in[15:0] = 16'h0000;
        wait_wrap(2);
        scan("t2_zero", {8'hFF, 8'hFF, 8'hFF, 8'hC0});

        data_in[15:0] = 16'h1234;
        wait_wrap(2);
        scan("t3_live", {8'hF9, 8'hA4, 8'hB0, 8'h99});
        hold = 1'b1;
        data_in[15:0] = 16'hFFFF;
        repeat (3) begin
            wait_wrap(1);
            scan("t3_hold", {8'hF9, 8'hA4, 8'hB0, 8'h19});
        end
        hold = 1'b0;
        wait_wrap(1);
        scan("t3_release", {8'hF9, 8'hA4, 8'hB0, 8'h99});
        wait_wrap(1);
        scan("t3_ffff", {8'h8E, 8'h8E, 8'h8E, 8'h8E});

        press(2);
        check("t4_glitch_a", ch_sel, 0);
        press(2);
        check("t4_glitch_b", ch_sel, 0);
        press(10);
        check("t4_ch1", ch_sel, 1);
        wait_wrap(1);
        scan("t4_disp1", {8'hF9, 8'hF9, 8'hF9, 8'hF9});
        press(3);
        check("t4_ch2", ch_sel, 2);
        wait_wrap(1);
        scan("t4_disp2", {8'hA4, 8'hA4, 8'hA4, 8'hA4});
        hold = 1'b1;
        press(3);
        check("t4_ch3", ch_sel, 3);
        wait_wrap(1);
        scan("t4_disp3_hold", {8'hB0, 8'hB0, 8'hB0, 8'h30});
        hold = 1'b0;
        press(3);
        check("t4_wrap0", ch_sel, 0);
        wait_wrap(1);
        scan("t4_disp0", {8'h8E, 8'h8E, 8'h8E, 8'h8E});

        // time the step to land on the same edge as the digit wrap
        wait_wrap(1);
        repeat (10) @(negedge Clk);
        selButton = 1'b1;
        wait_wrap(1);
        check("t6_ch", ch_sel, 1);
        scan("t6_new_ch", {8'hF9, 8'hF9, 8'hF9, 8'hF9});
        selButton = 1'b0;
        repeat (10) @(negedge Clk);
        check("t6_one_step", ch_sel, 1);

        wait_wrap(1);
        repeat (8) @(negedge Clk);
        selButton = 1'b1;
        repeat (2) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("t5_sel", selDisp, 4'hE);
        check("t5_seg", disp7Seg, 8'hC0);
        check("t5_ch", ch_sel, 0);
        selButton = 1'b0;
        @(negedge Clk) Rst_n = 1'b1;
        press(2);
        check("t5_short", ch_sel, 0);
        press(3);
        check("t5_full", ch_sel, 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
